alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU (4-bit opcode, two 32-bit operands, result + zero flag) between two requesters.
//  Typical requesters: requester 0 = execute stage, requester 1 = branch/address unit.
//  Arbitrates round-robin and drives the ALU inputs from the granted requester.
//  Registers each result into a per-requester response slot with valid/ready handshake.
//  Flags opcodes the ALU does not decode.
// PARAMETERS
//  WIDTH   32  operand/result width
//  OPW     4   ALU opcode width
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req_valid    in   2      request valid, bit i = requester i
//  req_ready    out  2      request accepted this cycle (one-hot or zero)
//  req_op0/1    in   OPW    opcode of requester 0/1
//  req_a0/1     in   WIDTH  operand A of requester 0/1
//  req_b0/1     in   WIDTH  operand B of requester 0/1
//  resp_valid   out  2      response slot i holds a result
//  resp_ready   in   2      requester i consumes its result
//  resp_out0/1  out  WIDTH  registered result, requester 0/1
//  resp_zero    out  2      registered zero flag, requester i
//  resp_err     out  2      registered illegal-opcode flag, requester i
//  alu_op       out  OPW    to ALU
//  alu_ina      out  WIDTH  to ALU
//  alu_inb      out  WIDTH  to ALU
//  alu_out      in   WIDTH  from ALU
//  alu_zero     in   1      from ALU
// BEHAVIOUR
//  Legal opcodes: 0000 and, 0001 or, 0010 add, 0011 xor, 0100 sll, 0101 srl, 0110 sub, 0111 sltu, 1000 slt, 1001 sra.
//  Reset (async): resp_valid=0, resp_out=0, resp_zero=0, resp_err=0, last_grant=1 (requester 0 wins first tie).
//  Slot free: free_i = !resp_valid[i] || resp_ready[i] (same-cycle drain frees the slot).
//  Eligibility: elig_i = req_valid[i] && free_i.
//  Grant (combinational):
//   - Both eligible: grant requester != last_grant.
//   - One eligible: grant that requester.
//   - None eligible: no grant.
//   - req_ready = grant vector; at most one bit set.
//  ALU drive (combinational): alu_op/ina/inb = granted requester's fields.
//   - No grant, or illegal op: drive 0010 / 0 / 0 so the ALU always sees a decoded op.
//  Posedge with grant g:
//   - resp_valid[g]<=1; last_grant<=g.
//   - Legal op: resp_out_g<=alu_out, resp_zero[g]<=alu_zero, resp_err[g]<=0.
//   - Illegal op: resp_out_g<=0, resp_zero[g]<=1, resp_err[g]<=1.
//  Posedge, slot i not granted and resp_ready[i]=1: resp_valid[i]<=0; data held.
//  Latency: accept in cycle t -> resp_valid high at t+1. Throughput: 1 op/cycle total.
//  Response slot: resp_out/zero/err stable while resp_valid=1 && !resp_ready.
//  resp_ready while resp_valid=0: ignored.
//  Fairness: a continuously eligible requester is granted within 2 cycles.
//  last_grant changes only on a grant.
//  Reset mid-operation: accepted-but-unregistered request is dropped; pending responses are lost.
//  Arithmetic: none in this block; widths pass through unchanged.
// STRUCTURE
//  Shared package alu_pkg: ALU opcode localparams (ALU_AND ... ALU_SRA), OPW, WIDTH, function alu_op_legal().
//  Sub-module rr_arb2: 2-way round-robin arbiter.
//   - Inputs: clk, rst, elig[1:0]. Outputs: grant[1:0].
//   - Owns last_grant.
//  Top level holds operand mux, legality check, two response slots.
// TESTING (bench instantiates the real ALU)
//  1. Req0 add 5+7, resp_ready=1 -> req_ready=01 same cycle; next cycle resp_valid=01, resp_out0=12, zero=0.
//  2. Both valid every cycle, both resp_ready=1; first tie after reset -> grants alternate 01,10,01,...
//     Req1 sub 3-3 -> resp_out1=0, zero=1.
//  3. Req0 resp_ready=0 with pending result 0xFFFFFFFF, req0 valid sll 1<<4:
//     -> req_ready[0]=0, resp_out0 holds 0xFFFFFFFF.
//     Raise resp_ready -> same-cycle accept, next cycle resp_out0=0x10.
//  4. Req1 op 1111 -> accepted, alu_op=0010 driven, next cycle resp_err=10, resp_out1=0.
//  5. slt 0xFFFFFFFF vs 1 -> 1; sltu same operands -> 0; sra 0x80000000 by 4 per ALU semantics.
//  6. Assert rst with both slots valid and req pending -> resp_valid=00 immediately (async), first tie after release goes to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU definitions: operand/opcode widths, opcode encodings, and the
// legality check used by the arbiter to decide whether a request reaches the ALU.
package alu_share_arbiter_pkg;

   localparam int ALU_WIDTH = 32;
   localparam int ALU_OPW   = 4;

   localparam logic [ALU_OPW-1:0] ALU_AND  = 4'h0;
   localparam logic [ALU_OPW-1:0] ALU_OR   = 4'h1;
   localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'h2;
   localparam logic [ALU_OPW-1:0] ALU_XOR  = 4'h3;
   localparam logic [ALU_OPW-1:0] ALU_SLL  = 4'h4;
   localparam logic [ALU_OPW-1:0] ALU_SRL  = 4'h5;
   localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'h6;
   localparam logic [ALU_OPW-1:0] ALU_SLTU = 4'h7;
   localparam logic [ALU_OPW-1:0] ALU_SLT  = 4'h8;
   localparam logic [ALU_OPW-1:0] ALU_SRA  = 4'h9;

   // Legal opcodes are a dense range starting at zero.
   function automatic logic alu_op_legal(input logic [ALU_OPW-1:0] op);
      return (op <= ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports: clk, rst (async, active high), elig[1:0] requester eligibility,
//        grant[1:0] combinational one-hot (or zero) grant.
//
// last_q | meaning
// -------+--------------------------------------------------
//   0    | requester 0 granted most recently -> 1 wins a tie
//   1    | requester 1 granted most recently -> 0 wins a tie (reset)
module alu_share_arbiter_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] elig,
   output logic [1:0] grant
);

   logic last_q;
   logic last_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= 1'b1;
      else     last_q <= last_d;
   end

   always_comb begin
      grant = 2'b00;
      case (elig)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // History only moves when someone is actually granted.
   always_comb begin
      last_d = last_q;
      if (grant[0])      last_d = 1'b0;
      else if (grant[1]) last_d = 1'b1;
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. Round-robin grant,
// operand mux toward the ALU, and one registered response slot per requester.
// Ports:
//   req_valid/req_ready       request handshake, bit i = requester i
//   req_op0/1, req_a0/1, req_b0/1  request fields
//   resp_valid/resp_ready     response handshake per slot
//   resp_out0/1, resp_zero, resp_err  registered result, zero flag, illegal-op flag
//   alu_op/alu_ina/alu_inb    drive to the shared ALU; alu_out/alu_zero back from it
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int OPW   = ALU_OPW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [OPW-1:0]   req_op0,
   input  logic [OPW-1:0]   req_op1,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_b1,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [WIDTH-1:0] resp_out0,
   output logic [WIDTH-1:0] resp_out1,
   output logic [1:0]       resp_zero,
   output logic [1:0]       resp_err,
   output logic [OPW-1:0]   alu_op,
   output logic [WIDTH-1:0] alu_ina,
   output logic [WIDTH-1:0] alu_inb,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero
);

   logic [1:0]       free;
   logic [1:0]       elig;
   logic [1:0]       grant;
   logic [OPW-1:0]   sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             sel_legal;

   logic [1:0]       valid_q, valid_d;
   logic [1:0]       zero_q,  zero_d;
   logic [1:0]       err_q,   err_d;
   logic [WIDTH-1:0] out_q [2];
   logic [WIDTH-1:0] out_d [2];

   // A slot being drained this cycle can take a new result in the same cycle.
   assign free = ~valid_q | resp_ready;
   assign elig = req_valid & free;

   alu_share_arbiter_rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .elig  (elig),
      .grant (grant)
   );

   assign req_ready = grant;

   always_comb begin
      sel_op    = grant[1] ? req_op1 : req_op0;
      sel_a     = grant[1] ? req_a1  : req_a0;
      sel_b     = grant[1] ? req_b1  : req_b0;
      sel_legal = alu_op_legal(sel_op);
   end

   // Idle or illegal requests park the ALU on add 0+0 so it always decodes.
   always_comb begin
      alu_op  = OPW'(ALU_ADD);
      alu_ina = '0;
      alu_inb = '0;
      if ((|grant) && sel_legal) begin
         alu_op  = sel_op;
         alu_ina = sel_a;
         alu_inb = sel_b;
      end
   end

   always_comb begin
      valid_d = valid_q;
      zero_d  = zero_q;
      err_d   = err_q;
      for (int i = 0; i < 2; i++) out_d[i] = out_q[i];
      for (int i = 0; i < 2; i++) begin
         if (grant[i]) begin
            valid_d[i] = 1'b1;
            if (sel_legal) begin
               out_d[i]  = alu_out;
               zero_d[i] = alu_zero;
               err_d[i]  = 1'b0;
            end else begin
               out_d[i]  = '0;
               zero_d[i] = 1'b1;
               err_d[i]  = 1'b1;
            end
         end else if (resp_ready[i]) begin
            valid_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         zero_q  <= '0;
         err_q   <= '0;
         for (int i = 0; i < 2; i++) out_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
         for (int i = 0; i < 2; i++) out_q[i] <= out_d[i];
      end
   end

   assign resp_valid = valid_q;
   assign resp_zero  = zero_q;
   assign resp_err   = err_q;
   assign resp_out0  = out_q[0];
   assign resp_out1  = out_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [3:0]  req_op0 = '0, req_op1 = '0;
   logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready = '0;
   logic [31:0] resp_out0, resp_out1;
   logic [1:0]  resp_zero, resp_err;
   logic [3:0]  alu_op;
   logic [31:0] alu_ina, alu_inb, alu_out;
   logic        alu_zero;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [31:0] out;
      logic        zero;
      logic        err;
   } resp_t;

   resp_t      sb_q0[$];
   resp_t      sb_q1[$];
   logic [1:0] model_v = '0;

   always #5 clk = ~clk;

   alu_share_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_a0(req_a0), .req_a1(req_a1),
      .req_b0(req_b0), .req_b1(req_b1),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_out0(resp_out0), .resp_out1(resp_out1),
      .resp_zero(resp_zero), .resp_err(resp_err),
      .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb),
      .alu_out(alu_out), .alu_zero(alu_zero)
   );

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_ADD:  return a + b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << b[4:0];
         ALU_SRL:  return a >> b[4:0];
         ALU_SUB:  return a - b;
         ALU_SLTU: return {31'b0, (a < b)};
         ALU_SLT:  return {31'b0, ($signed(a) < $signed(b))};
         ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         default:  return 32'h0;
      endcase
   endfunction

   // The shared ALU itself lives in the bench.
   always_comb begin
      alu_out  = alu_ref(alu_op, alu_ina, alu_inb);
      alu_zero = (alu_out == 32'h0);
   end

   function automatic resp_t exp_resp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      resp_t r;
      if (op <= 4'd9) begin
         r.out  = alu_ref(op, a, b);
         r.zero = (r.out == 32'h0);
         r.err  = 1'b0;
      end else begin
         r.out  = 32'h0;
         r.zero = 1'b1;
         r.err  = 1'b1;
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Called at a negedge; applies the handshake inputs, checks the combinational
   // outputs and consumed responses, then advances to the next negedge.
   task automatic step(input logic [1:0] v, input logic [1:0] rr, input logic [1:0] exp_rdy, input string nm);
      logic [3:0]  eop;
      logic [31:0] ea;
      resp_t       e;
      req_valid  = v;
      resp_ready = rr;
      #1;
      chk({nm, " req_ready"}, {30'b0, req_ready}, {30'b0, exp_rdy});
      chk({nm, " resp_valid"}, {30'b0, resp_valid}, {30'b0, model_v});
      eop = 4'd2;
      ea  = 32'h0;
      if (exp_rdy[0] && req_op0 <= 4'd9) begin eop = req_op0; ea = req_a0; end
      if (exp_rdy[1] && req_op1 <= 4'd9) begin eop = req_op1; ea = req_a1; end
      chk({nm, " alu_op"}, {28'b0, alu_op}, {28'b0, eop});
      chk({nm, " alu_ina"}, alu_ina, ea);
      if (resp_valid[0] && rr[0]) begin
         if (sb_q0.size() == 0) chk({nm, " resp0 unexpected"}, 32'h1, 32'h0);
         else begin
            e = sb_q0.pop_front();
            chk({nm, " resp_out0"}, resp_out0, e.out);
            chk({nm, " resp0 zero/err"}, {30'b0, resp_zero[0], resp_err[0]}, {30'b0, e.zero, e.err});
         end
      end
      if (resp_valid[1] && rr[1]) begin
         if (sb_q1.size() == 0) chk({nm, " resp1 unexpected"}, 32'h1, 32'h0);
         else begin
            e = sb_q1.pop_front();
            chk({nm, " resp_out1"}, resp_out1, e.out);
            chk({nm, " resp1 zero/err"}, {30'b0, resp_zero[1], resp_err[1]}, {30'b0, e.zero, e.err});
         end
      end
      if (exp_rdy[0]) sb_q0.push_back(exp_resp(req_op0, req_a0, req_b0));
      if (exp_rdy[1]) sb_q1.push_back(exp_resp(req_op1, req_a1, req_b1));
      for (int i = 0; i < 2; i++)
         if (exp_rdy[i]) model_v[i] = 1'b1;
         else if (rr[i]) model_v[i] = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_req(input logic [3:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] b1);
      req_op0 = o0; req_a0 = a0; req_b0 = b0;
      req_op1 = o1; req_a1 = a1; req_b1 = b1;
   endtask

   typedef struct {
      logic [1:0]  v;
      logic [3:0]  op0;
      logic [31:0] a0, b0;
      logic [3:0]  op1;
      logic [31:0] a1, b1;
      logic [1:0]  rdy;
      logic        chk_en;
      logic        slot;
      logic [31:0] out;
      logic        zero;
      logic        err;
   } vec_t;

   vec_t tbl[13];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{2'b11, 4'h2, 32'd1, 32'd2, 4'h6, 32'd3, 32'd3, 2'b01, 1'b1, 1'b0, 32'd3, 1'b0, 1'b0};
      tbl[1]  = '{2'b11, 4'h2, 32'd1, 32'd2, 4'h6, 32'd3, 32'd3, 2'b10, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0};
      tbl[2]  = '{2'b11, 4'h2, 32'd10, 32'd20, 4'h6, 32'd7, 32'd2, 2'b01, 1'b1, 1'b0, 32'd30, 1'b0, 1'b0};
      tbl[3]  = '{2'b11, 4'h2, 32'd10, 32'd20, 4'h6, 32'd7, 32'd2, 2'b10, 1'b1, 1'b1, 32'd5, 1'b0, 1'b0};
      tbl[4]  = '{2'b01, 4'h2, 32'd5, 32'd7, 4'h0, 32'd0, 32'd0, 2'b01, 1'b1, 1'b0, 32'd12, 1'b0, 1'b0};
      tbl[5]  = '{2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
      tbl[6]  = '{2'b10, 4'h0, 32'd0, 32'd0, 4'hF, 32'd9, 32'd9, 2'b10, 1'b1, 1'b1, 32'd0, 1'b1, 1'b1};
      tbl[7]  = '{2'b01, 4'h8, 32'hFFFFFFFF, 32'd1, 4'h0, 32'd0, 32'd0, 2'b01, 1'b1, 1'b0, 32'd1, 1'b0, 1'b0};
      tbl[8]  = '{2'b01, 4'h7, 32'hFFFFFFFF, 32'd1, 4'h0, 32'd0, 32'd0, 2'b01, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0};
      tbl[9]  = '{2'b10, 4'h0, 32'd0, 32'd0, 4'h9, 32'h80000000, 32'd4, 2'b10, 1'b1, 1'b1, 32'hF8000000, 1'b0, 1'b0};
      tbl[10] = '{2'b11, 4'h0, 32'hF0F0, 32'h0FF0, 4'h1, 32'h1200, 32'h0034, 2'b01, 1'b1, 1'b0, 32'h00F0, 1'b0, 1'b0};
      tbl[11] = '{2'b11, 4'h3, 32'hAAAA, 32'h5555, 4'h5, 32'h80000000, 32'd31, 2'b10, 1'b1, 1'b1, 32'd1, 1'b0, 1'b0};
      tbl[12] = '{2'b00, 4'h0, 32'd0, 32'd0, 4'h0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset resp_valid", {30'b0, resp_valid}, 32'h0);
      chk("reset resp_out0", resp_out0, 32'h0);
      chk("reset resp_out1", resp_out1, 32'h0);
      chk("reset zero/err", {28'b0, resp_zero, resp_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Table: alternation on ties, single requester, illegal op, compare/shift corners
      for (int k = 0; k < 13; k++) begin
         set_req(tbl[k].op0, tbl[k].a0, tbl[k].b0, tbl[k].op1, tbl[k].a1, tbl[k].b1);
         step(tbl[k].v, 2'b11, tbl[k].rdy, $sformatf("vec%0d", k));
         if (tbl[k].chk_en) begin
            chk($sformatf("vec%0d out", k), tbl[k].slot ? resp_out1 : resp_out0, tbl[k].out);
            chk($sformatf("vec%0d zero/err", k),
                {30'b0, resp_zero[tbl[k].slot], resp_err[tbl[k].slot]},
                {30'b0, tbl[k].zero, tbl[k].err});
         end
      end

      // Back-pressure on slot 0: pending result held, then same-cycle drain and refill
      set_req(4'h1, 32'hFFFFFFFF, 32'h0, 4'h0, 32'h0, 32'h0);
      step(2'b01, 2'b00, 2'b01, "bp fill");
      chk("bp fill out0", resp_out0, 32'hFFFFFFFF);
      set_req(4'h4, 32'd1, 32'd4, 4'h0, 32'h0, 32'h0);
      step(2'b01, 2'b00, 2'b00, "bp stall a");
      chk("bp hold a", resp_out0, 32'hFFFFFFFF);
      step(2'b01, 2'b00, 2'b00, "bp stall b");
      chk("bp hold b", resp_out0, 32'hFFFFFFFF);
      step(2'b01, 2'b01, 2'b01, "bp drain");
      chk("bp refill out0", resp_out0, 32'h10);
      step(2'b00, 2'b01, 2'b00, "bp empty");

      // Async reset with both slots full and a request pending
      set_req(4'h2, 32'd8, 32'd9, 4'h2, 32'd2, 32'd3);
      step(2'b11, 2'b00, 2'b10, "rst fill1");
      step(2'b11, 2'b00, 2'b01, "rst fill2");
      req_valid  = 2'b11;
      resp_ready = 2'b00;
      #2;
      chk("rst pending ready", {30'b0, req_ready}, 32'h0);
      chk("rst pre valid", {30'b0, resp_valid}, 32'h3);
      rst = 1'b1;
      #1;
      chk("rst async valid", {30'b0, resp_valid}, 32'h0);
      chk("rst async out1", resp_out1, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      sb_q0.delete();
      sb_q1.delete();
      model_v = '0;
      step(2'b11, 2'b11, 2'b01, "post rst tie");
      step(2'b00, 2'b11, 2'b00, "post rst drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
